// File: rtl/morph3x3_stream.sv
// 3x3 grey-scale morphology (erode = min, dilate = max) over a streamed
// column window. Each accepted beat carries one column of three vertically
// aligned pixels; the result for column k-1 is emitted after column k arrives,
// and an internal flush cycle emits the last column of every row.
//
// state | meaning
// ------+------------------------------------------------------------------
// RUN   | accepting beats; window shifts on every accepted beat
// FLUSH | one cycle after the last column: shift in an empty slot, no accept

module morph3x3_stream #(
   parameter int DATA_W    = 24,
   parameter int PIC_WIDTH = 250
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic              shape,
   input  logic              valid_in,
   output logic              in_ready,
   input  logic              row_first,
   input  logic              row_last,
   input  logic [DATA_W-1:0] din_top,
   input  logic [DATA_W-1:0] din_mid,
   input  logic [DATA_W-1:0] din_bot,
   output logic              valid_out,
   output logic [DATA_W-1:0] dout,
   output logic              eol_out
);

   localparam int CNT_W = 11;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(PIC_WIDTH - 1);

   typedef struct packed {
      logic [DATA_W-1:0] top;
      logic [DATA_W-1:0] mid;
      logic [DATA_W-1:0] bot;
      logic              row_first;
      logic              row_last;
      logic              col_valid;
   } slot_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   slot_t             win_l_q, win_l_d;
   slot_t             win_c_q, win_c_d;
   slot_t             win_r_q, win_r_d;
   slot_t             in_slot;
   logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
   logic              pending_q, pending_d;
   logic              pending_eol_q, pending_eol_d;
   logic              cfg_mode_q, cfg_mode_d;
   logic              cfg_shape_q, cfg_shape_d;
   logic              valid_out_q, valid_out_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              eol_out_q, eol_out_d;
   logic              accept;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] cand [9];
   logic [8:0]        incl;
   logic              n_ok, s_ok, w_ok, e_ok;

   assign accept  = valid_in && in_ready;
   assign in_slot = {din_top, din_mid, din_bot, row_first, row_last, 1'b1};

   assign valid_out = valid_out_q;
   assign dout      = dout_q;
   assign eol_out   = eol_out_q;

   // Neighbourhood around the centre slot; index = 3*row + column (NW..SE)
   assign n_ok = !win_c_q.row_first;
   assign s_ok = !win_c_q.row_last;
   assign w_ok = win_l_q.col_valid;
   assign e_ok = win_r_q.col_valid;

   assign cand[0] = win_l_q.top;
   assign cand[1] = win_c_q.top;
   assign cand[2] = win_r_q.top;
   assign cand[3] = win_l_q.mid;
   assign cand[4] = win_c_q.mid;
   assign cand[5] = win_r_q.mid;
   assign cand[6] = win_l_q.bot;
   assign cand[7] = win_c_q.bot;
   assign cand[8] = win_r_q.bot;

   // Diagonals need both their row and column neighbour, and the square shape
   assign incl[0] = cfg_shape_q && n_ok && w_ok;
   assign incl[1] = n_ok;
   assign incl[2] = cfg_shape_q && n_ok && e_ok;
   assign incl[3] = w_ok;
   assign incl[4] = 1'b1;
   assign incl[5] = e_ok;
   assign incl[6] = cfg_shape_q && s_ok && w_ok;
   assign incl[7] = s_ok;
   assign incl[8] = cfg_shape_q && s_ok && e_ok;

   // Min/max fold; excluded pixels stay at the identity so they never win
   always_comb begin
      result = cfg_mode_q ? '0 : '1;
      for (int i = 0; i < 9; i++) begin
         if (incl[i]) begin
            if (cfg_mode_q) begin
               if (cand[i] > result) result = cand[i];
            end else begin
               if (cand[i] < result) result = cand[i];
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // FSM next state: the last column forces exactly one flush cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (accept && (col_cnt_q == LAST_COL)) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = (state_q == ST_RUN);
   end

   // Window shift, column count, row config and result staging
   always_comb begin
      win_l_d       = win_l_q;
      win_c_d       = win_c_q;
      win_r_d       = win_r_q;
      col_cnt_d     = col_cnt_q;
      pending_d     = 1'b0;
      pending_eol_d = 1'b0;
      cfg_mode_d    = cfg_mode_q;
      cfg_shape_d   = cfg_shape_q;
      if (accept) begin
         win_l_d = win_c_q;
         // centre becomes column 0: its west neighbour belongs to no image column
         if (col_cnt_q == CNT_W'(1)) win_l_d.col_valid = 1'b0;
         win_c_d   = win_r_q;
         win_r_d   = in_slot;
         col_cnt_d = (col_cnt_q == LAST_COL) ? '0 : col_cnt_q + 1'b1;
         pending_d = (col_cnt_q != '0);
         if (col_cnt_q == '0) begin
            cfg_mode_d  = mode;
            cfg_shape_d = shape;
         end
      end else if (state_q == ST_FLUSH) begin
         win_l_d       = win_c_q;
         win_c_d       = win_r_q;
         win_r_d       = '0;
         pending_d     = 1'b1;
         pending_eol_d = 1'b1;
      end
   end

   // Output register: result comes from the window as it stood before the edge
   always_comb begin
      valid_out_d = pending_q;
      eol_out_d   = pending_q && pending_eol_q;
      dout_d      = pending_q ? result : dout_q;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_l_q       <= '0;
         win_c_q       <= '0;
         win_r_q       <= '0;
         col_cnt_q     <= '0;
         pending_q     <= 1'b0;
         pending_eol_q <= 1'b0;
         cfg_mode_q    <= 1'b0;
         cfg_shape_q   <= 1'b0;
         valid_out_q   <= 1'b0;
         dout_q        <= '0;
         eol_out_q     <= 1'b0;
      end else begin
         win_l_q       <= win_l_d;
         win_c_q       <= win_c_d;
         win_r_q       <= win_r_d;
         col_cnt_q     <= col_cnt_d;
         pending_q     <= pending_d;
         pending_eol_q <= pending_eol_d;
         cfg_mode_q    <= cfg_mode_d;
         cfg_shape_q   <= cfg_shape_d;
         valid_out_q   <= valid_out_d;
         dout_q        <= dout_d;
         eol_out_q     <= eol_out_d;
      end
   end

endmodule
